// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch-writeback end-point: ROB age tag, writeback,
// redirect and FTQ-training payloads, plus the ROB age comparison.
package branch_redirect_ctrl_pkg;

  localparam int ROB_IDX_W = 5;
  localparam int FTQ_IDX_W = 6;
  localparam int PC_W      = 32;
  localparam int OFF_W     = 4;

  typedef enum logic [2:0] {
    isNone = 3'd0,
    isCond = 3'd1,
    isJal  = 3'd2,
    isJalr = 3'd3,
    isCall = 3'd4,
    isRet  = 3'd5
  } branch_type_t;

  typedef struct packed {
    logic                 flg;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    branch_type_t         branch_type;
    robIdx_t              rob_idx;
    logic [FTQ_IDX_W-1:0] ftq_idx;
    logic                 has_mispred;
    logic                 branch_taken;
    logic [OFF_W-1:0]     fallthruOffset;
    logic [PC_W-1:0]      target_pc;
    logic [PC_W-1:0]      branch_npc;
  } branchwbInfo_t;

  typedef struct packed {
    robIdx_t              rob_idx;
    logic [FTQ_IDX_W-1:0] ftq_idx;
    logic [PC_W-1:0]      npc;
    branch_type_t         branch_type;
    logic                 taken;
  } redirectInfo_t;

  typedef struct packed {
    logic [FTQ_IDX_W-1:0] ftq_idx;
    logic [OFF_W-1:0]     fallthruOffset;
    logic [PC_W-1:0]      target_pc;
    logic                 taken;
    logic                 mispred;
    branch_type_t         branch_type;
  } ftqUpdInfo_t;

  // The wrap flag flips each time the ROB index wraps, so differing flags
  // invert the index comparison.
  function automatic logic rob_older(robIdx_t a, robIdx_t b);
    return (a.flg == b.flg) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_branchwb_fifo.sv
// Multi-push / single-pop FIFO for FTQ training entries. Pushes land in
// ascending port order; the head is read straight from the storage array.
module branch_redirect_ctrl_branchwb_fifo #(
  parameter int  NUM_PUSH = 2,
  parameter int  DEPTH    = 8,
  parameter type T        = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_PUSH-1:0]        push_vld_i,
  input  T                           push_data_i [NUM_PUSH],
  input  logic                       pop_i,
  output logic                       vld_o,
  output T                           head_o,
  output logic [$clog2(DEPTH):0]     cnt_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  T              mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   npush;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] widx [NUM_PUSH];
  logic          empty, full;

  always_comb begin
    npush = '0;
    for (int p = 0; p < NUM_PUSH; p++) begin
      widx[p] = wptr_q[AW-1:0] + npush[AW-1:0];
      if (push_vld_i[p]) npush = npush + ONE;
    end
  end

  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign cnt_q      = wptr_q - rptr_q;
  assign wptr_d     = wptr_q + npush;
  assign rptr_d     = rptr_q + (pop_i ? ONE : '0);
  assign cnt_next_o = wptr_d - rptr_d;
  assign vld_o      = !empty;
  assign head_o     = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PUSH; p++) begin
      if (push_vld_i[p]) mem_q[widx[p]] <= push_data_i[p];
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (int'(cnt_q) + int'(npush) - (pop_i ? 1 : 0)) <= DEPTH);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(full && (|push_vld_i)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && empty));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch-writeback end-point: filters wrong-path writebacks, issues one
// registered redirect for the oldest mispredict and queues FTQ training.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int NUM_BRU   = 2,
  parameter int UPD_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BRU-1:0]  i_branchwb_vld,
  input  branchwbInfo_t       i_branchwbInfo [NUM_BRU],
  input  logic                i_flush,
  output logic                o_wb_stall,
  output logic                o_redirect_vld,
  output redirectInfo_t       o_redirectInfo,
  output logic                o_ftqupd_vld,
  input  logic                i_ftqupd_rdy,
  output ftqUpdInfo_t         o_ftqupdInfo
);

  localparam int CW = $clog2(UPD_DEPTH) + 1;

  logic               stall_q, stall_d;
  logic               blk_vld_q, blk_vld_d;
  robIdx_t            blk_rob_q, blk_rob_d;
  logic               redir_vld_q;
  redirectInfo_t      redir_info_q;
  logic [NUM_BRU-1:0] acc;
  logic               sel_vld;
  branchwbInfo_t      sel_info;
  ftqUpdInfo_t        upd [NUM_BRU];
  logic               pop;
  logic [CW-1:0]      cnt_next;

  // Anything not older than the outstanding redirect is on the wrong path.
  always_comb begin
    for (int p = 0; p < NUM_BRU; p++) begin
      acc[p] = i_branchwb_vld[p] && !stall_q && !i_flush &&
               !(blk_vld_q && !rob_older(i_branchwbInfo[p].rob_idx, blk_rob_q));
      upd[p] = '{ftq_idx:        i_branchwbInfo[p].ftq_idx,
                 fallthruOffset: i_branchwbInfo[p].fallthruOffset,
                 target_pc:      i_branchwbInfo[p].target_pc,
                 taken:          i_branchwbInfo[p].branch_taken,
                 mispred:        i_branchwbInfo[p].has_mispred,
                 branch_type:    i_branchwbInfo[p].branch_type};
    end
  end

  // Strictly-older replaces, so the lower port keeps a tie.
  always_comb begin
    sel_vld  = 1'b0;
    sel_info = i_branchwbInfo[0];
    for (int p = 0; p < NUM_BRU; p++) begin
      if (acc[p] && i_branchwbInfo[p].has_mispred &&
          (!sel_vld || rob_older(i_branchwbInfo[p].rob_idx, sel_info.rob_idx))) begin
        sel_vld  = 1'b1;
        sel_info = i_branchwbInfo[p];
      end
    end
  end

  always_comb begin
    blk_vld_d = blk_vld_q;
    blk_rob_d = blk_rob_q;
    if (i_flush) begin
      blk_vld_d = 1'b0;
    end else if (sel_vld) begin
      blk_vld_d = 1'b1;
      blk_rob_d = sel_info.rob_idx;
    end
  end

  // FTQ port is valid/ready: an entry transfers on a cycle where both are high;
  // the payload is stable while valid is high and ready is low.
  assign pop     = o_ftqupd_vld && i_ftqupd_rdy;
  assign stall_d = (UPD_DEPTH - int'(cnt_next)) < NUM_BRU;

  branch_redirect_ctrl_branchwb_fifo #(
    .NUM_PUSH (NUM_BRU),
    .DEPTH    (UPD_DEPTH),
    .T        (ftqUpdInfo_t)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_vld_i  (acc),
    .push_data_i (upd),
    .pop_i       (pop),
    .vld_o       (o_ftqupd_vld),
    .head_o      (o_ftqupdInfo),
    .cnt_next_o  (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q     <= 1'b0;
      blk_vld_q   <= 1'b0;
      redir_vld_q <= 1'b0;
    end else begin
      stall_q     <= stall_d;
      blk_vld_q   <= blk_vld_d;
      redir_vld_q <= sel_vld;
    end
  end

  always_ff @(posedge clk) begin
    blk_rob_q <= blk_rob_d;
    if (sel_vld) begin
      redir_info_q <= '{rob_idx:     sel_info.rob_idx,
                        ftq_idx:     sel_info.ftq_idx,
                        npc:         sel_info.branch_npc,
                        branch_type: sel_info.branch_type,
                        taken:       sel_info.branch_taken};
    end
  end

  assign o_wb_stall     = stall_q;
  assign o_redirect_vld = redir_vld_q;
  assign o_redirectInfo = redir_info_q;

  for (genvar p = 0; p < NUM_BRU; p++) begin : g_chk
    a_no_none: assert property (@(posedge clk) disable iff (rst)
      i_branchwb_vld[p] |-> (i_branchwbInfo[p].branch_type != isNone));
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: redirect selection, wrong-path
// filtering, flush priority, FTQ FIFO ordering, back-pressure and reset.
module tb_branch_redirect_ctrl;
  import branch_redirect_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    i_branchwb_vld;
  branchwbInfo_t i_branchwbInfo [2];
  logic          i_flush;
  logic          o_wb_stall;
  logic          o_redirect_vld;
  redirectInfo_t o_redirectInfo;
  logic          o_ftqupd_vld;
  logic          i_ftqupd_rdy;
  ftqUpdInfo_t   o_ftqupdInfo;

  int n_vec = 0;
  int n_err = 0;
  logic [FTQ_IDX_W-1:0] exp_q[$];
  logic [FTQ_IDX_W-1:0] got_q[$];

  branch_redirect_ctrl #(.NUM_BRU(2), .UPD_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_branchwb_vld (i_branchwb_vld),
    .i_branchwbInfo (i_branchwbInfo),
    .i_flush        (i_flush),
    .o_wb_stall     (o_wb_stall),
    .o_redirect_vld (o_redirect_vld),
    .o_redirectInfo (o_redirectInfo),
    .o_ftqupd_vld   (o_ftqupd_vld),
    .i_ftqupd_rdy   (i_ftqupd_rdy),
    .o_ftqupdInfo   (o_ftqupdInfo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic set_wb(input int p, input logic flg, input logic [4:0] idx,
                        input logic [5:0] ftq, input logic mis, input logic [31:0] npc);
    i_branchwb_vld[p]                = 1'b1;
    i_branchwbInfo[p].branch_type    = isCond;
    i_branchwbInfo[p].rob_idx.flg    = flg;
    i_branchwbInfo[p].rob_idx.idx    = idx;
    i_branchwbInfo[p].ftq_idx        = ftq;
    i_branchwbInfo[p].has_mispred    = mis;
    i_branchwbInfo[p].branch_taken   = mis;
    i_branchwbInfo[p].fallthruOffset = 4'(p + 1);
    i_branchwbInfo[p].target_pc      = npc;
    i_branchwbInfo[p].branch_npc     = npc;
  endtask

  task automatic idle();
    i_branchwb_vld = 2'b00;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
  endtask

  task automatic drain_fifo();
    got_q.delete();
    i_ftqupd_rdy = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (!o_ftqupd_vld) break;
      got_q.push_back(o_ftqupdInfo.ftq_idx);
      @(negedge clk);
    end
    i_ftqupd_rdy = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; i_flush = 1'b0; i_ftqupd_rdy = 1'b0; idle();
    for (int p = 0; p < 2; p++) set_wb(p, 1'b0, 5'd0, 6'd0, 1'b0, 32'h0);
    idle();
    repeat (3) @(negedge clk);
    n_vec++; if (o_redirect_vld !== 1'b0) begin n_err++; $display("FAIL reset_redirect_vld got %b exp 0", o_redirect_vld); end
    n_vec++; if (o_ftqupd_vld !== 1'b0) begin n_err++; $display("FAIL reset_ftqupd_vld got %b exp 0", o_ftqupd_vld); end
    n_vec++; if (o_wb_stall !== 1'b0) begin n_err++; $display("FAIL reset_wb_stall got %b exp 0", o_wb_stall); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_mispredict();
    set_wb(0, 1'b0, 5'd5, 6'd1, 1'b1, 32'h8000_1000); exp_q.push_back(6'd1);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b1) begin n_err++; $display("FAIL t1_redirect_vld got %b exp 1", o_redirect_vld); end
    n_vec++; if (o_redirectInfo.npc !== 32'h8000_1000) begin n_err++; $display("FAIL t1_npc got %h exp 80001000", o_redirectInfo.npc); end
    n_vec++; if (o_redirectInfo.rob_idx !== 6'd5) begin n_err++; $display("FAIL t1_rob got %h exp 05", o_redirectInfo.rob_idx); end
    n_vec++; if (o_ftqupd_vld !== 1'b1 || o_ftqupdInfo.mispred !== 1'b1) begin n_err++; $display("FAIL t1_ftq_head got vld=%b mis=%b exp 1 1", o_ftqupd_vld, o_ftqupdInfo.mispred); end
    @(negedge clk);
    n_vec++; if (o_redirect_vld !== 1'b0) begin n_err++; $display("FAIL t1_pulse_width got %b exp 0", o_redirect_vld); end
    drain_fifo();
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL t1_fifo_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t1_fifo_entry%0d exp %0d", i, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_dual_mispredict();
    do_flush();
    set_wb(0, 1'b0, 5'd9, 6'd2, 1'b1, 32'h8000_3000);
    set_wb(1, 1'b0, 5'd3, 6'd3, 1'b1, 32'h8000_2000);
    exp_q.push_back(6'd2); exp_q.push_back(6'd3);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b1) begin n_err++; $display("FAIL t2_redirect_vld got %b exp 1", o_redirect_vld); end
    n_vec++; if (o_redirectInfo.rob_idx !== 6'd3) begin n_err++; $display("FAIL t2_rob got %h exp 03", o_redirectInfo.rob_idx); end
    n_vec++; if (o_redirectInfo.npc !== 32'h8000_2000) begin n_err++; $display("FAIL t2_npc got %h exp 80002000", o_redirectInfo.npc); end
    set_wb(1, 1'b0, 5'd7, 6'd10, 1'b1, 32'h8000_4000);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b0) begin n_err++; $display("FAIL t2_younger_redirect got %b exp 0", o_redirect_vld); end
    drain_fifo();
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL t2_fifo_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t2_fifo_entry%0d exp %0d", i, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_wrap_age();
    do_flush();
    set_wb(0, 1'b0, 5'd30, 6'd4, 1'b1, 32'h8000_5000); exp_q.push_back(6'd4);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b1 || o_redirectInfo.rob_idx !== 6'd30) begin n_err++; $display("FAIL t3_first_redirect got vld=%b rob=%h exp 1 1e", o_redirect_vld, o_redirectInfo.rob_idx); end
    set_wb(0, 1'b1, 5'd2, 6'd5, 1'b1, 32'h8000_6000);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b0) begin n_err++; $display("FAIL t3_wrapped_dropped got %b exp 0", o_redirect_vld); end
    set_wb(0, 1'b0, 5'd28, 6'd6, 1'b1, 32'h8000_7000); exp_q.push_back(6'd6);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b1 || o_redirectInfo.rob_idx !== 6'd28) begin n_err++; $display("FAIL t3_older_redirect got vld=%b rob=%h exp 1 1c", o_redirect_vld, o_redirectInfo.rob_idx); end
    n_vec++; if (o_redirectInfo.npc !== 32'h8000_7000) begin n_err++; $display("FAIL t3_npc got %h exp 80007000", o_redirectInfo.npc); end
    drain_fifo();
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL t3_fifo_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t3_fifo_entry%0d exp %0d", i, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_flush_priority();
    set_wb(0, 1'b0, 5'd1, 6'd7, 1'b1, 32'h8000_8000);
    i_flush = 1'b1;
    @(negedge clk); idle(); i_flush = 1'b0;
    n_vec++; if (o_redirect_vld !== 1'b0) begin n_err++; $display("FAIL t4_flush_redirect got %b exp 0", o_redirect_vld); end
    n_vec++; if (o_ftqupd_vld !== 1'b0) begin n_err++; $display("FAIL t4_flush_push got %b exp 0", o_ftqupd_vld); end
    set_wb(0, 1'b1, 5'd2, 6'd8, 1'b1, 32'h8000_9000); exp_q.push_back(6'd8);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b1 || o_redirectInfo.rob_idx !== 6'h22) begin n_err++; $display("FAIL t4_after_flush got vld=%b rob=%h exp 1 22", o_redirect_vld, o_redirectInfo.rob_idx); end
    drain_fifo();
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL t4_fifo_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t4_fifo_entry%0d exp %0d", i, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_pressure();
    do_flush();
    i_ftqupd_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_wb(0, 1'b0, 5'(2*k + 1), 6'(16 + 2*k), 1'b0, 32'h8000_a000);
      set_wb(1, 1'b0, 5'(2*k + 2), 6'(17 + 2*k), 1'b0, 32'h8000_b000);
      exp_q.push_back(6'(16 + 2*k)); exp_q.push_back(6'(17 + 2*k));
      @(negedge clk); idle();
      n_vec++; if (o_wb_stall !== (k == 3)) begin n_err++; $display("FAIL t5_fill_stall%0d got %b exp %b", k, o_wb_stall, (k == 3)); end
    end
    set_wb(0, 1'b0, 5'd20, 6'd30, 1'b0, 32'h8000_c000);
    set_wb(1, 1'b0, 5'd21, 6'd31, 1'b0, 32'h8000_c000);
    @(negedge clk); idle();
    n_vec++; if (o_wb_stall !== 1'b1) begin n_err++; $display("FAIL t5_hold_stall got %b exp 1", o_wb_stall); end
    i_ftqupd_rdy = 1'b1;
    for (int c = 0; c < 24; c++) begin
      n_vec++; if (o_wb_stall !== ((8 - exp_q.size()) < 2)) begin n_err++; $display("FAIL t5_drain_stall held=%0d got %b", exp_q.size(), o_wb_stall); end
      if (!o_ftqupd_vld) break;
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL t5_extra_entry got %0d exp none", o_ftqupdInfo.ftq_idx); end
      else begin
        if (o_ftqupdInfo.ftq_idx !== exp_q[0]) begin n_err++; $display("FAIL t5_drain_order got %0d exp %0d", o_ftqupdInfo.ftq_idx, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    i_ftqupd_rdy = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL t5_lost_entries got %0d left exp 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_op();
    do_flush();
    set_wb(0, 1'b0, 5'd10, 6'd32, 1'b0, 32'h8000_d000);
    set_wb(1, 1'b0, 5'd11, 6'd33, 1'b0, 32'h8000_d000);
    @(negedge clk);
    set_wb(0, 1'b0, 5'd12, 6'd34, 1'b0, 32'h8000_d000);
    set_wb(1, 1'b0, 5'd13, 6'd35, 1'b0, 32'h8000_d000);
    @(negedge clk); idle();
    set_wb(0, 1'b0, 5'd4, 6'd36, 1'b1, 32'h8000_e000);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b1) begin n_err++; $display("FAIL t6_pending_redirect got %b exp 1", o_redirect_vld); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (o_redirect_vld !== 1'b0) begin n_err++; $display("FAIL t6_rst_redirect got %b exp 0", o_redirect_vld); end
    n_vec++; if (o_ftqupd_vld !== 1'b0) begin n_err++; $display("FAIL t6_rst_ftqupd got %b exp 0", o_ftqupd_vld); end
    n_vec++; if (o_wb_stall !== 1'b0) begin n_err++; $display("FAIL t6_rst_stall got %b exp 0", o_wb_stall); end
    rst = 1'b0;
    @(negedge clk);
    set_wb(1, 1'b1, 5'd20, 6'd41, 1'b1, 32'h8000_f000); exp_q.push_back(6'd41);
    @(negedge clk); idle();
    n_vec++; if (o_redirect_vld !== 1'b1 || o_redirectInfo.rob_idx !== 6'h34) begin n_err++; $display("FAIL t6_post_rst got vld=%b rob=%h exp 1 34", o_redirect_vld, o_redirectInfo.rob_idx); end
    drain_fifo();
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL t6_fifo_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t6_fifo_entry%0d exp %0d", i, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_mispredict();
    test_dual_mispredict();
    test_wrap_age();
    test_flush_priority();
    test_back_pressure();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
